logic_gate_pipe: RTL and testbench

- Parametrised, registered successor to the single-bit inverter.
- Performs a selectable bitwise logic operation on two WIDTH-bit operands, including NOT. Supported ops: NOT, BUF, AND, OR, XOR, NAND, NOR, XNOR.
- Result passes through a STAGES-deep valid/ready pipeline and is accompanied by zero and parity flags.
- Sits between any producer/consumer pair in the logic-gate library that needs back-pressured, registered gate results.

---
 rtl/logic_gate_pipe_pkg.sv | 18 +
 rtl/logic_gate_stage.sv | 47 ++++
 rtl/logic_gate_pipe.sv | 105 ++++++++++
 tb/tb_logic_gate_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the registered logic-gate pipeline.
// Operation encodings and the flag field width carried with each result.
package logic_gate_pipe_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_BUF  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_XNOR = 3'b111
    } gate_op_e;

    localparam int FLAG_W = 2;

endpackage

// File: rtl/logic_gate_stage.sv
// One valid/ready register slice of the gate pipeline.
// The load strobe comes from the ready chain computed in the top level.
module logic_gate_stage
    import logic_gate_pipe_pkg::*;
#(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          v_q;
    logic          v_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (load) begin
            v_d = in_valid;
            // Data only moves with a valid beat, so idle inputs never leak in.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_valid = v_q;
    assign out_data  = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Selectable bitwise gate with zero/parity flags, pushed through a
// back-pressured register pipeline and a saturating completion counter.
module logic_gate_pipe
    import logic_gate_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             P,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count
);

    localparam int DW = WIDTH + FLAG_W;

    logic [WIDTH-1:0] fn_y;
    logic [DW-1:0]    in_data;
    logic [STAGES-1:0] vld;
    logic [DW-1:0]    dat [STAGES];
    logic [STAGES:0]  rdy;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        fn_y = '0;
        case (gate_op_e'(OP))
            OP_NOT:  fn_y = ~A;
            OP_BUF:  fn_y = A;
            OP_AND:  fn_y = A & B;
            OP_OR:   fn_y = A | B;
            OP_XOR:  fn_y = A ^ B;
            OP_NAND: fn_y = ~(A & B);
            OP_NOR:  fn_y = ~(A | B);
            OP_XNOR: fn_y = ~(A ^ B);
            default: fn_y = '0;
        endcase
    end

    assign in_data = {~|fn_y, ^fn_y, fn_y};

    // A stage may load when empty or when everything downstream moves.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          s_valid;
        logic [DW-1:0] s_data;
        if (k == 0) begin : g_head
            assign s_valid = in_valid;
            assign s_data  = in_data;
        end else begin : g_body
            assign s_valid = vld[k-1];
            assign s_data  = dat[k-1];
        end
        logic_gate_stage #(
            .DW(DW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (rdy[k]),
            .in_valid (s_valid),
            .in_data  (s_data),
            .out_valid(vld[k]),
            .out_data (dat[k])
        );
    end

    assign in_ready      = rdy[0] && !rst;
    assign out_valid     = vld[STAGES-1];
    assign {Z, P, Y}     = dat[STAGES-1];

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: main 8-bit/2-stage instance plus
// 1-stage and 4-stage instances with a 4-bit counter.
module tb_logic_gate_pipe;

    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a, b, y;
    logic [2:0]  op;
    logic        in_valid, in_ready, out_valid, out_ready, z, p;
    logic [15:0] op_count;

    logic [7:0]  s_a;
    logic [2:0]  s_op;
    logic        s_in_valid, s_out_ready;
    logic        s1_in_ready, s1_out_valid, s1_z, s1_p;
    logic [7:0]  s1_y;
    logic [3:0]  s1_cnt;
    logic        s4_in_ready, s4_out_valid, s4_z, s4_p;
    logic [7:0]  s4_y;
    logic [3:0]  s4_cnt;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .STAGES(ST), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .OP(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .Y(y), .Z(z), .P(p), .out_valid(out_valid),
        .out_ready(out_ready), .op_count(op_count)
    );

    logic_gate_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(4)) u_s1 (
        .clk(clk), .rst(rst), .A(s_a), .B(s_a), .OP(s_op),
        .in_valid(s_in_valid), .in_ready(s1_in_ready),
        .Y(s1_y), .Z(s1_z), .P(s1_p), .out_valid(s1_out_valid),
        .out_ready(s_out_ready), .op_count(s1_cnt)
    );

    logic_gate_pipe #(.WIDTH(8), .STAGES(4), .CNT_W(4)) u_s4 (
        .clk(clk), .rst(rst), .A(s_a), .B(s_a), .OP(s_op),
        .in_valid(s_in_valid), .in_ready(s4_in_ready),
        .Y(s4_y), .Z(s4_z), .P(s4_p), .out_valid(s4_out_valid),
        .out_ready(s_out_ready), .op_count(s4_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int exp_cnt = 0;
    int stall_cnt = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [9:0] d;
        int         t;
    } sb_t;

    sb_t        sb[$];
    logic [9:0] seen[$];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gate(input logic [2:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] w);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x;
            3'd2:    return x & w;
            3'd3:    return x | w;
            3'd4:    return x ^ w;
            3'd5:    return ~(x & w);
            3'd6:    return ~(x | w);
            default: return ~(x ^ w);
        endcase
    endfunction

    function automatic logic [9:0] pack(input logic [7:0] r);
        return {(r == 8'h00), ^r, r};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
        end else begin
            check_eq("op_count", 64'(op_count), 64'(exp_cnt));
            if (out_valid && out_ready) begin
                if (exp_cnt < 65535) exp_cnt++;
                seen.push_back({z, p, y});
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    check_eq("data", 64'({z, p, y}), 64'(e.d));
                    if (lat_chk)
                        check_eq("latency", 64'(cyc - e.t), 64'(ST));
                end
            end
            if (in_valid && in_ready) begin
                e.d = pack(gate(op, a, b));
                e.t = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [2:0] o, input logic [7:0] x,
                              input logic [7:0] w);
        int n;
        n = 0;
        op = o;
        a = x;
        b = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        stall_cnt += n;
        if (n >= 100) check_eq("accept_timeout", 64'(n), 64'(0));
        align();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", 64'(sb.size()), 64'(0));
        align();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] t2 [8];
        int lat1, lat4, n_acc, guard;
        t2 = '{10'h05A, 10'h0A5, 10'h024, 10'h0BD,
               10'h099, 10'h0DB, 10'h042, 10'h066};
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        s_a = '0; s_op = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_y", 64'(y), 64'(0));
        check_eq("rst_cnt", 64'(op_count), 64'(0));
        align();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(in_ready), 64'(1));

        // single NOT beat, exact latency
        align();
        lat_chk = 1'b1;
        seen.delete();
        drive_beat(3'd0, 8'h0F, 8'h00);
        drain();
        check_eq("t1_count", 64'(seen.size()), 64'(1));
        if (seen.size() > 0) check_eq("t1_y", 64'(seen[0]), 64'(10'h0F0));
        check_eq("t1_op_count", 64'(op_count), 64'(1));

        // all ops back to back
        seen.delete();
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) drive_beat(3'(i), 8'hA5, 8'h3C);
        drain();
        check_eq("t2_stalls", 64'(stall_cnt), 64'(0));
        check_eq("t2_count", 64'(seen.size()), 64'(8));
        for (int i = 0; i < 8 && i < seen.size(); i++)
            check_eq("t2_seq", 64'(seen[i]), 64'(t2[i]));
        lat_chk = 1'b0;

        // back-pressure fills the pipe, then release
        seen.delete();
        out_ready = 1'b0;
        drive_beat(3'd1, 8'h11, 8'h00);
        drive_beat(3'd1, 8'h22, 8'h00);
        op = 3'd1; a = 8'h33; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t3_in_ready", 64'(in_ready), 64'(0));
            check_eq("t3_valid", 64'(out_valid), 64'(1));
            check_eq("t3_hold_y", 64'(y), 64'(8'h11));
        end
        align();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_full_swap", 64'(in_ready), 64'(1));
        align();
        in_valid = 1'b0;
        drain();
        check_eq("t3_count", 64'(seen.size()), 64'(3));
        if (seen.size() == 3) begin
            check_eq("t3_o0", 64'(seen[0]), 64'(10'h011));
            check_eq("t3_o1", 64'(seen[1]), 64'(10'h022));
            check_eq("t3_o2", 64'(seen[2]), 64'(10'h033));
        end

        // zero flag, then random traffic with random back-pressure
        seen.delete();
        drive_beat(3'd2, 8'hF0, 8'h0F);
        drain();
        if (seen.size() > 0) check_eq("t4_zero", 64'(seen[0]), 64'(10'h200));
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            out_ready = 1'($urandom);
            in_valid = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
            align();
            guard++;
        end
        check_eq("t4_accepted", 64'(n_acc), 64'(1000));
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset with two beats in flight
        out_ready = 1'b0;
        drive_beat(3'd1, 8'h5A, 8'h00);
        drive_beat(3'd1, 8'hC3, 8'h00);
        rst = 1'b1;
        align();
        @(negedge clk);
        check_eq("t5_valid", 64'(out_valid), 64'(0));
        check_eq("t5_y", 64'(y), 64'(0));
        check_eq("t5_cnt", 64'(op_count), 64'(0));
        check_eq("t5_ready", 64'(in_ready), 64'(0));
        align();
        rst = 1'b0;
        out_ready = 1'b1;
        seen.delete();
        stall_cnt = 0;
        drive_beat(3'd0, 8'h0F, 8'h00);
        check_eq("t5_first_accept", 64'(stall_cnt), 64'(0));
        drain();
        check_eq("t5_count", 64'(seen.size()), 64'(1));

        // 1- and 4-stage latency, 4-bit counter saturation
        s_op = 3'd0;
        s_a = 8'h0F;
        s_in_valid = 1'b1;
        @(negedge clk);
        check_eq("t6_s1_ready", 64'(s1_in_ready), 64'(1));
        check_eq("t6_s4_ready", 64'(s4_in_ready), 64'(1));
        align();
        s_in_valid = 1'b0;
        lat1 = -1;
        lat4 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (s1_out_valid && lat1 < 0) begin
                lat1 = k;
                check_eq("t6_s1_y", 64'({s1_z, s1_p, s1_y}), 64'(10'h0F0));
            end
            if (s4_out_valid && lat4 < 0) begin
                lat4 = k;
                check_eq("t6_s4_y", 64'({s4_z, s4_p, s4_y}), 64'(10'h0F0));
            end
        end
        check_eq("t6_s1_lat", 64'(lat1), 64'(1));
        check_eq("t6_s4_lat", 64'(lat4), 64'(4));
        align();
        s_in_valid = 1'b1;
        repeat (19) align();
        s_in_valid = 1'b0;
        repeat (8) align();
        @(negedge clk);
        check_eq("t6_s1_sat", 64'(s1_cnt), 64'(15));
        check_eq("t6_s4_sat", 64'(s4_cnt), 64'(15));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
